// File: rtl/axis_mux_n.sv
// N-input AXI4-Stream frame multiplexer: grant held for a whole frame, external-select or
// round-robin arbitration, output registered through a 2-entry skid buffer.
module axis_mux_n #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int ARB_MODE    = 0,
  parameter int SEL_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic [S_COUNT-1:0]            input_axis_tvalid,
  output logic [S_COUNT-1:0]            input_axis_tready,
  input  logic [S_COUNT-1:0]            input_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] input_axis_tuser,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic                          output_axis_tlast,
  output logic [USER_WIDTH-1:0]         output_axis_tuser,
  input  logic                          enable,
  input  logic [SEL_WIDTH-1:0]          select,
  output logic                          active,
  output logic [SEL_WIDTH-1:0]          grant
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_reg, state_next;
  logic [SEL_WIDTH-1:0]   grant_reg, grant_next;
  logic                   rr_started_reg, rr_started_next;

  logic                   ready_int_reg, ready_int_next;
  logic                   out_valid_reg, out_valid_next;
  logic                   temp_valid_reg, temp_valid_next;
  logic [DATA_WIDTH-1:0]  out_tdata_reg, temp_tdata_reg;
  logic [KEEP_WIDTH-1:0]  out_tkeep_reg, temp_tkeep_reg;
  logic                   out_tlast_reg, temp_tlast_reg;
  logic [USER_WIDTH-1:0]  out_tuser_reg, temp_tuser_reg;
  logic                   load_out_in, load_out_temp, load_temp;

  logic [DATA_WIDTH-1:0]  port_tdata [S_COUNT];
  logic [KEEP_WIDTH-1:0]  port_tkeep [S_COUNT];
  logic [USER_WIDTH-1:0]  port_tuser [S_COUNT];

  logic [DATA_WIDTH-1:0]  sel_tdata;
  logic [KEEP_WIDTH-1:0]  sel_tkeep;
  logic [USER_WIDTH-1:0]  sel_tuser;
  logic                   sel_tvalid, sel_tlast;
  logic                   accept;
  logic                   sel_req;
  logic                   rr_found;
  logic [SEL_WIDTH-1:0]   rr_pick;
  int                     rr_base, rr_idx;

  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
    assign port_tdata[gi] = input_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign port_tkeep[gi] = (KEEP_ENABLE != 0) ? input_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH] : '1;
    assign port_tuser[gi] = (USER_ENABLE != 0) ? input_axis_tuser[gi*USER_WIDTH +: USER_WIDTH] : '0;
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tuser  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_req    = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_reg == SEL_WIDTH'(i)) begin
        sel_tdata  = port_tdata[i];
        sel_tkeep  = port_tkeep[i];
        sel_tuser  = port_tuser[i];
        sel_tvalid = input_axis_tvalid[i];
        sel_tlast  = input_axis_tlast[i];
      end
      // an out-of-range select never matches any port, so it can never grant
      if (select == SEL_WIDTH'(i) && input_axis_tvalid[i]) sel_req = 1'b1;
    end
  end

  // Round-robin scan: starts one past the last grant, or at port 0 until the first grant.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = 0;
    rr_base  = rr_started_reg ? int'(grant_reg) + 1 : 0;
    if (rr_base >= S_COUNT) rr_base = 0;
    for (int k = 0; k < S_COUNT; k++) begin
      rr_idx = rr_base + k;
      if (rr_idx >= S_COUNT) rr_idx = rr_idx - S_COUNT;
      if (!rr_found && input_axis_tvalid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = SEL_WIDTH'(rr_idx);
      end
    end
  end

  assign accept = (state_reg == ACTIVE) && ready_int_reg && sel_tvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_started_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_started_reg <= rr_started_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rr_started_next = rr_started_reg;
    case (state_reg)
      IDLE: begin
        if (ARB_MODE == 0) begin
          if (enable && sel_req) begin
            grant_next = select;
            state_next = ACTIVE;
          end
        end else if (enable && rr_found) begin
          grant_next      = rr_pick;
          rr_started_next = 1'b1;
          state_next      = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept && sel_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    input_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++)
      input_axis_tready[i] = (state_reg == ACTIVE) && (grant_reg == SEL_WIDTH'(i)) && ready_int_reg;
    active = (state_reg == ACTIVE);
  end

  assign grant = grant_reg;

  // Skid buffer: ready toward the inputs depends only on registered state.
  always_comb begin
    out_valid_next  = out_valid_reg;
    temp_valid_next = temp_valid_reg;
    load_out_in     = 1'b0;
    load_out_temp   = 1'b0;
    load_temp       = 1'b0;
    ready_int_next  = output_axis_tready || (!temp_valid_reg && (!out_valid_reg || !accept));
    if (ready_int_reg) begin
      if (output_axis_tready || !out_valid_reg) begin
        out_valid_next = accept;
        load_out_in    = accept;
      end else begin
        temp_valid_next = accept;
        load_temp       = accept;
      end
    end else if (output_axis_tready) begin
      out_valid_next  = temp_valid_reg;
      temp_valid_next = 1'b0;
      load_out_temp   = temp_valid_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_int_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      temp_valid_reg <= 1'b0;
      out_tdata_reg  <= '0;
      out_tkeep_reg  <= '0;
      out_tlast_reg  <= 1'b0;
      out_tuser_reg  <= '0;
      temp_tdata_reg <= '0;
      temp_tkeep_reg <= '0;
      temp_tlast_reg <= 1'b0;
      temp_tuser_reg <= '0;
    end else begin
      ready_int_reg  <= ready_int_next;
      out_valid_reg  <= out_valid_next;
      temp_valid_reg <= temp_valid_next;
      if (load_out_in) begin
        out_tdata_reg <= sel_tdata;
        out_tkeep_reg <= sel_tkeep;
        out_tlast_reg <= sel_tlast;
        out_tuser_reg <= sel_tuser;
      end else if (load_out_temp) begin
        out_tdata_reg <= temp_tdata_reg;
        out_tkeep_reg <= temp_tkeep_reg;
        out_tlast_reg <= temp_tlast_reg;
        out_tuser_reg <= temp_tuser_reg;
      end
      if (load_temp) begin
        temp_tdata_reg <= sel_tdata;
        temp_tkeep_reg <= sel_tkeep;
        temp_tlast_reg <= sel_tlast;
        temp_tuser_reg <= sel_tuser;
      end
    end
  end

  assign output_axis_tdata  = out_tdata_reg;
  assign output_axis_tkeep  = (KEEP_ENABLE != 0) ? out_tkeep_reg : '1;
  assign output_axis_tvalid = out_valid_reg;
  assign output_axis_tlast  = out_tlast_reg;
  assign output_axis_tuser  = (USER_ENABLE != 0) ? out_tuser_reg : '0;

endmodule
